// File: rtl/pgr_fft_pkg.sv
// Shared definitions for the burst radix-2 constant-geometry FFT datapath:
// read-sequencer state encoding and the per-level twiddle index.
package pgr_fft_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_WB,
    S_DONE
  } fft_rd_state_t;

  // Twiddle ROM index for butterfly k at level l: k with its low
  // (log2n-1-l) bits cleared. Level 0 always yields 0, the last level yields k.
  function automatic logic [15:0] tw_idx(input logic [15:0] k,
                                         input int unsigned l,
                                         input int unsigned log2n);
    int unsigned sh;
    sh = log2n - 1 - l;
    return (k >> sh) << sh;
  endfunction

endpackage

// File: rtl/pgr_fft_rd_addr_gen_if.sv
// Control/address bundle between the read-address sequencer and the
// output switch / butterfly twiddle ROM.
interface pgr_fft_rd_addr_gen_if #(
  parameter int LOG2N      = 10,
  parameter int ADDR_WIDTH = 18,
  parameter int LVL_WIDTH  = 4
);

  logic                  i_start;
  logic                  i_hold;
  logic                  i_wb_level_done;
  logic [ADDR_WIDTH-1:0] o_rd_addr;
  logic                  o_rd_valid;
  logic                  o_first_level;
  logic [LVL_WIDTH-1:0]  o_level;
  logic [LOG2N-2:0]      o_tw_addr;
  logic                  o_busy;
  logic                  o_done;

  // Sequencer side
  modport master (
    input  i_start, i_hold, i_wb_level_done,
    output o_rd_addr, o_rd_valid, o_first_level, o_level, o_tw_addr,
           o_busy, o_done
  );

  // Controller / consumer side
  modport slave (
    output i_start, i_hold, i_wb_level_done,
    input  o_rd_addr, o_rd_valid, o_first_level, o_level, o_tw_addr,
           o_busy, o_done
  );

endinterface

// File: rtl/pgr_fft_rd_addr_gen.sv
// Read-address sequencer: walks LOG2N levels, issuing N/2 bank-pair reads
// per level, and waits for write-back completion between levels.
module pgr_fft_rd_addr_gen
  import pgr_fft_pkg::*;
#(
  parameter int LOG2N      = 10,
  parameter int ADDR_WIDTH = 18,
  parameter int LVL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pgr_fft_rd_addr_gen_if.master rd
);

  localparam int KW = LOG2N - 1;
  localparam logic [LVL_WIDTH-1:0] L_LAST = LVL_WIDTH'(LOG2N - 1);

  fft_rd_state_t        state;
  logic [KW-1:0]        k;
  logic [LVL_WIDTH-1:0] l;
  logic [KW-1:0]        tw_k;

  // Twiddle index for the butterfly about to be issued
  always_comb begin
    tw_k = KW'(tw_idx(16'(k), 32'(l), LOG2N));
  end

  // Sequencer FSM with k/l counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      k                <= '0;
      l                <= '0;
      rd.o_rd_addr     <= '0;
      rd.o_rd_valid    <= 1'b0;
      rd.o_first_level <= 1'b0;
      rd.o_level       <= '0;
      rd.o_tw_addr     <= '0;
      rd.o_busy        <= 1'b0;
      rd.o_done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          rd.o_rd_valid    <= 1'b0;
          rd.o_first_level <= 1'b0;
          rd.o_done        <= 1'b0;
          rd.o_busy        <= 1'b0;
          // FSM is already idle in the done-pulse cycle while o_busy is
          // still high; a start seen then is still treated as busy.
          if (rd.i_start && !rd.o_busy) begin
            k     <= '0;
            l     <= '0;
            state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          rd.o_busy        <= 1'b1;
          rd.o_first_level <= (l == '0);
          rd.o_level       <= l;
          if (rd.i_hold) begin
            rd.o_rd_valid <= 1'b0;
          end else begin
            rd.o_rd_valid <= 1'b1;
            rd.o_rd_addr  <= ADDR_WIDTH'(k);
            rd.o_tw_addr  <= tw_k;
            if (k == '1) begin
              k     <= '0;
              state <= S_WAIT_WB;
            end else begin
              k <= k + 1'b1;
            end
          end
        end

        S_WAIT_WB: begin
          rd.o_rd_valid    <= 1'b0;
          rd.o_first_level <= 1'b0;
          rd.o_busy        <= 1'b1;
          if (rd.i_wb_level_done) begin
            if (l < L_LAST) begin
              l     <= l + 1'b1;
              state <= S_ISSUE;
            end else begin
              state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          rd.o_rd_valid    <= 1'b0;
          rd.o_first_level <= 1'b0;
          rd.o_busy        <= 1'b1;
          rd.o_done        <= 1'b1;
          state            <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pgr_fft_rd_addr_gen.sv
// Self-checking bench for pgr_fft_rd_addr_gen (LOG2N=4).
module tb_pgr_fft_rd_addr_gen;

  localparam int LOG2N      = 4;
  localparam int ADDR_WIDTH = 18;
  localparam int LVL_WIDTH  = 4;
  localparam int HALF       = 1 << (LOG2N - 1);
  localparam int TOTAL      = LOG2N * HALF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] tw;
    logic [31:0] lvl;
    logic        first;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  beat_t obs_q[$];
  int    obs_cyc[$];
  int    n_valid = 0;
  int    n_done = 0;
  int    cyc = 0;

  pgr_fft_rd_addr_gen_if #(.LOG2N(LOG2N), .ADDR_WIDTH(ADDR_WIDTH), .LVL_WIDTH(LVL_WIDTH)) rd ();

  pgr_fft_rd_addr_gen #(.LOG2N(LOG2N), .ADDR_WIDTH(ADDR_WIDTH), .LVL_WIDTH(LVL_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  // Record every live read and done pulse, sampled on the falling edge
  always @(negedge clk) begin
    beat_t bt;
    cyc++;
    if (rst_n && rd.o_rd_valid) begin
      bt.addr  = 32'(rd.o_rd_addr);
      bt.tw    = 32'(rd.o_tw_addr);
      bt.lvl   = 32'(rd.o_level);
      bt.first = rd.o_first_level;
      obs_q.push_back(bt);
      obs_cyc.push_back(cyc);
      n_valid++;
    end
    if (rst_n && rd.o_done) n_done++;
  end

  // Reference: butterfly k of level l pairs with twiddle k rounded down
  // to a multiple of the level's twiddle span 2^(LOG2N-1-l).
  function automatic int exp_tw(input int k, input int l);
    int span;
    span = 1 << (LOG2N - 1 - l);
    return k - (k % span);
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // mode 0 basic (wb 3 cycles after level end), 1 stall at level 1 k=3,
  // 2 spurious start/wb, 3 random holds and wb gaps, 4 reset at level 2 k=5
  task automatic drive_run(input int mode, input int b, input bit send_start, output bit ok);
    int guard;
    int held;
    int gap;
    int kk;
    ok = 1'b1;
    if (send_start) begin
      rd.i_start = 1'b1;
      step();
      rd.i_start = 1'b0;
    end
    for (int l = 0; l < LOG2N; l++) begin
      held  = 0;
      guard = 0;
      while (n_valid - b < (l + 1) * HALF) begin
        kk = n_valid - b - l * HALF;
        rd.i_hold = 1'b0;
        rd.i_wb_level_done = 1'b0;
        rd.i_start = 1'b0;
        if (mode == 1 && l == 1 && kk == 3 && held < 2) begin
          rd.i_hold = 1'b1;
          held++;
        end
        if (mode == 3) rd.i_hold = ($urandom_range(0, 3) == 0);
        if (mode == 2 && l == 2 && kk == 2) rd.i_start = 1'b1;
        if (mode == 2 && l == 1 && kk == 4) rd.i_wb_level_done = 1'b1;
        if (mode == 4 && l == 2 && kk == 5) begin
          rst_n = 1'b0;
          return;
        end
        step();
        guard++;
        if (guard > 200) begin
          n_total++;
          $display("FAIL issue_timeout: level %0d got %0d valids want %0d", l, kk, HALF);
          rd.i_hold = 1'b0;
          rd.i_start = 1'b0;
          rd.i_wb_level_done = 1'b0;
          ok = 1'b0;
          return;
        end
      end
      rd.i_hold = 1'b0;
      rd.i_start = 1'b0;
      rd.i_wb_level_done = 1'b0;
      gap = (mode == 3) ? int'($urandom_range(0, 5)) : 3;
      if (mode == 3 && $urandom_range(0, 1) == 1) rd.i_hold = 1'b1;
      repeat (gap) step();
      rd.i_hold = 1'b0;
      rd.i_wb_level_done = 1'b1;
      step();
      rd.i_wb_level_done = 1'b0;
    end
  endtask

  task automatic check_run(input int b, input string name);
    beat_t e;
    n_total++;
    if (n_valid - b !== TOTAL)
      $display("FAIL %s_count: got %0d valids want %0d", name, n_valid - b, TOTAL);
    else n_pass++;
    for (int i = 0; i < TOTAL && b + i < obs_q.size(); i++) begin
      e.lvl   = 32'(i / HALF);
      e.addr  = 32'(i % HALF);
      e.tw    = 32'(exp_tw(i % HALF, i / HALF));
      e.first = (i / HALF == 0);
      n_total++;
      if (obs_q[b + i] !== e)
        $display("FAIL %s_beat%0d: got addr=%0d tw=%0d lvl=%0d first=%0b want addr=%0d tw=%0d lvl=%0d first=%0b",
                 name, i, obs_q[b + i].addr, obs_q[b + i].tw, obs_q[b + i].lvl, obs_q[b + i].first,
                 e.addr, e.tw, e.lvl, e.first);
      else n_pass++;
    end
  endtask

  task automatic finish_run(input string name);
    n_total++;
    if (rd.o_done !== 1'b0) $display("FAIL %s_done_early: got %0b want 0", name, rd.o_done);
    else n_pass++;
    step();
    n_total++;
    if (rd.o_done !== 1'b1 || rd.o_busy !== 1'b1)
      $display("FAIL %s_done_pulse: got done=%0b busy=%0b want done=1 busy=1", name, rd.o_done, rd.o_busy);
    else n_pass++;
    step();
    n_total++;
    if (rd.o_done !== 1'b0 || rd.o_busy !== 1'b0)
      $display("FAIL %s_idle: got done=%0b busy=%0b want done=0 busy=0", name, rd.o_done, rd.o_busy);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd.i_start = 1'b0;
    rd.i_hold = 1'b0;
    rd.i_wb_level_done = 1'b0;
    step();
    step();
    n_total++;
    if ({rd.o_rd_addr, rd.o_tw_addr, rd.o_level} !== '0)
      $display("FAIL reset_vectors: got addr=%0d tw=%0d lvl=%0d want 0", rd.o_rd_addr, rd.o_tw_addr, rd.o_level);
    else n_pass++;
    n_total++;
    if ({rd.o_rd_valid, rd.o_first_level, rd.o_busy, rd.o_done} !== 4'b0)
      $display("FAIL reset_flags: got valid=%0b first=%0b busy=%0b done=%0b want 0",
               rd.o_rd_valid, rd.o_first_level, rd.o_busy, rd.o_done);
    else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int b, d0;
    bit ok;
    b = n_valid;
    d0 = n_done;
    drive_run(0, b, 1'b1, ok);
    finish_run("basic");
    check_run(b, "basic");
    n_total++;
    if (n_done - d0 !== 1) $display("FAIL basic_done_count: got %0d want 1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_stall();
    int b;
    bit ok;
    b = n_valid;
    drive_run(1, b, 1'b1, ok);
    finish_run("stall");
    check_run(b, "stall");
    if (obs_cyc.size() >= b + TOTAL) begin
      n_total++;
      if (obs_cyc[b + HALF + 3] - obs_cyc[b + HALF + 2] !== 3)
        $display("FAIL stall_gap: got %0d cycles want 3", obs_cyc[b + HALF + 3] - obs_cyc[b + HALF + 2]);
      else n_pass++;
      n_total++;
      if (obs_cyc[b + HALF - 1] - obs_cyc[b] !== HALF - 1)
        $display("FAIL issue_rate: got %0d cycles want %0d", obs_cyc[b + HALF - 1] - obs_cyc[b], HALF - 1);
      else n_pass++;
    end
  endtask

  task automatic test_spurious();
    int b, d0;
    bit ok;
    b = n_valid;
    d0 = n_done;
    drive_run(2, b, 1'b1, ok);
    finish_run("spurious");
    check_run(b, "spurious");
    n_total++;
    if (n_done - d0 !== 1) $display("FAIL spurious_done_count: got %0d want 1", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int b, d0;
    bit ok;
    b = n_valid;
    d0 = n_done;
    drive_run(4, b, 1'b1, ok);
    #1;
    n_total++;
    if ({rd.o_rd_addr, rd.o_tw_addr, rd.o_level, rd.o_rd_valid, rd.o_first_level, rd.o_busy, rd.o_done} !== '0)
      $display("FAIL midrun_reset: got addr=%0d tw=%0d lvl=%0d valid=%0b busy=%0b want all 0",
               rd.o_rd_addr, rd.o_tw_addr, rd.o_level, rd.o_rd_valid, rd.o_busy);
    else n_pass++;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    n_total++;
    if (n_done !== d0 || rd.o_busy !== 1'b0)
      $display("FAIL midrun_no_done: got done_pulses=%0d busy=%0b want 0 0", n_done - d0, rd.o_busy);
    else n_pass++;
    b = n_valid;
    drive_run(0, b, 1'b1, ok);
    finish_run("after_reset");
    check_run(b, "after_reset");
  endtask

  task automatic test_back_to_back();
    int b, b2, d0;
    bit ok;
    b = n_valid;
    d0 = n_done;
    drive_run(0, b, 1'b1, ok);
    step();
    n_total++;
    if (rd.o_done !== 1'b1) $display("FAIL b2b_done: got %0b want 1", rd.o_done);
    else n_pass++;
    rd.i_start = 1'b1;
    step();
    rd.i_start = 1'b1;
    step();
    rd.i_start = 1'b0;
    n_total++;
    if (rd.o_rd_valid !== 1'b0 || rd.o_busy !== 1'b0)
      $display("FAIL b2b_start_ignored: got valid=%0b busy=%0b want 0 0", rd.o_rd_valid, rd.o_busy);
    else n_pass++;
    check_run(b, "b2b_first");
    step();
    n_total++;
    if (rd.o_rd_valid !== 1'b1 || rd.o_rd_addr !== '0 || rd.o_first_level !== 1'b1 || rd.o_busy !== 1'b1)
      $display("FAIL b2b_second_start: got valid=%0b addr=%0d first=%0b busy=%0b want 1 0 1 1",
               rd.o_rd_valid, rd.o_rd_addr, rd.o_first_level, rd.o_busy);
    else n_pass++;
    b2 = n_valid - 1;
    drive_run(0, b2, 1'b0, ok);
    finish_run("b2b_second");
    check_run(b2, "b2b_second");
    n_total++;
    if (n_done - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", n_done - d0);
    else n_pass++;
  endtask

  task automatic test_random();
    int b;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      b = n_valid;
      drive_run(3, b, 1'b1, ok);
      finish_run("random");
      check_run(b, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_spurious();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pgr_fft_rd_addr_gen.md
# pgr_fft_rd_addr_gen

Read-address sequencer for the burst radix-2 constant-geometry FFT/IFFT core. It sits directly upstream of the output switch (`pgr_fft_o_switch`) and drives that block's `i_rd_addr`, `i_rd_valid` and `first_level` inputs. It also drives the twiddle ROM address and level index for the butterfly. It walks all LOG2N levels, issuing N/2 sequential bank-pair reads per level, and waits for write-back completion between levels so the in-place RAM is never read before it is rewritten.

## Interface
- LOG2N, default 10, log2 of FFT length N; legal range 3..16.
- ADDR_WIDTH, default 18, read-address width; must be ≥ LOG2N-1; upper bits are driven 0.
- LVL_WIDTH, default 4, width of the level index; must hold LOG2N-1.

- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  single-cycle pulse; begins a transform; honoured only in IDLE.
- i_hold  in  1  stall request (RAM arbitration); freezes issue while high.
- i_wb_level_done  in  1  single-cycle pulse from write-back: current level fully written.
- o_rd_addr  out  ADDR_WIDTH  bank-pair read address k.
- o_rd_valid  out  1  o_rd_addr is a live read this cycle.
- o_first_level  out  1  high throughout level 0 issue window.
- o_level  out  LVL_WIDTH  current level l.
- o_tw_addr  out  LOG2N-1  twiddle ROM index for butterfly k.
- o_busy  out  1  high from accepted start until done.
- o_done  out  1  single-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT_WB, DONE.
- IDLE: on i_start, clear k and l, then go to ISSUE. o_busy rises on the next edge.
- ISSUE, each cycle with i_hold=0: assert valid with addr=k and tw=(k >> (LOG2N-1-l)) << (LOG2N-1-l), then k++. For l=0, tw is always 0. For l=LOG2N-1, tw=k.
- ISSUE with i_hold=1: valid=0; k, l and the other outputs hold.
- At k=N/2-1 (issued), k wraps to 0 and the FSM goes to WAIT_WB.
- WAIT_WB: valid=0. On i_wb_level_done:
  - if l<LOG2N-1, l++ and return to ISSUE;
  - otherwise go to DONE.
- i_wb_level_done is ignored in every state except WAIT_WB.
- DONE: o_done=1 for one cycle, o_busy falls, return to IDLE.
- i_start is ignored while busy (ISSUE, WAIT_WB, DONE).
- o_first_level = (l==0) && state==ISSUE. It is also held during stalls inside level 0.
- i_hold during WAIT_WB, IDLE or DONE has no effect.
- Reset mid-operation: all state is immediately abandoned and the FSM returns to IDLE. No done pulse is produced.

## Timing
- All outputs are registered.
- Reset values:
  - o_rd_addr=0, o_tw_addr=0, o_level=0;
  - o_rd_valid=0, o_first_level=0, o_busy=0, o_done=0.
- i_start sampled at edge T: first valid (addr 0, level 0, first_level=1) appears after edge T+1, together with o_busy=1.
- Issue rate: one address per unstalled cycle.
- i_hold sampled at edge E blocks the output update at E. Valid is low in the following cycle; latency is 1.
- Last address of a level → WAIT_WB on the next edge.
- i_wb_level_done at edge E → first address of the next level is visible after E+1.
- Final i_wb_level_done at edge E → o_done high after E+1, o_busy low after E+2.
- Unstalled transform with zero write-back wait: LOG2N·N/2 valid cycles.

## Structure
- Shared package `pgr_fft_pkg` holds:
  - the FSM state encoding constants (IDLE/ISSUE/WAIT_WB/DONE);
  - the twiddle-index function tw_idx(k, l, LOG2N), reused by the butterfly twiddle ROM.
- Single module; no sub-module needed. The k/l counters and the FSM live inline.

## Test plan
- Basic run: LOG2N=4, pulse start, answer each WAIT_WB with wb_level_done 3 cycles later.
  - Required: 4 levels × 8 valids; addr 0..7 per level.
  - tw per level: level 0 all 0; level 1 0,0,0,0,4,4,4,4; level 2 0,0,2,2,4,4,6,6; level 3 0..7.
  - first_level high only for level 0; one o_done.
- Stall: hold=1 for 2 cycles at k=3 of level 1.
  - Required: valid low for exactly 2 cycles, addr resumes at 3, tw unchanged, total valid count still 32.
- Spurious inputs: start pulsed during level 2, and wb_level_done pulsed during ISSUE of level 1.
  - Required: both ignored; address sequence identical to the basic run.
- Reset mid-run: rst_n low at level 2, k=5.
  - Required: all outputs 0 immediately.
  - A subsequent start produces a clean run from level 0, addr 0.
- Back-to-back: start pulsed in the cycle o_done is high (ignored), then again the next cycle (accepted).
  - Required: the second transform begins 1 cycle later.
- Integration with pgr_fft_o_switch: with LOG2N=4, connect the outputs and feed known bank data.
  - Required: butterfly_vld count = 32; addr_index follows o_rd_addr delayed by 2.
